// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
// Register addresses are carried at HZ_AW bits so any REG_AW <= HZ_AW fits.
package pipeline_pkg;

    localparam int HZ_AW       = 8;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic             valid;
        logic [HZ_AW-1:0] rd;
        logic             reg_write;
        logic             is_load;
        logic [HZ_AW-1:0] rs;
        logic [HZ_AW-1:0] rt;
    } hz_entry_t;

    // Stage index at which a producer's result becomes forwardable.
    // Without forwarding the result only exists once it has left the tracker.
    function automatic int avail(input logic is_load, input int load_lat,
                                 input bit fwd_en, input int depth);
        if (!fwd_en) return depth;
        return is_load ? 1 + load_lat : 1;
    endfunction

    function automatic logic hz_match(input hz_entry_t e, input logic [HZ_AW-1:0] r);
        return e.valid && e.reg_write && (e.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_stage_tracker.sv
// Shift register of in-flight instructions after ID (entry 0 = EX).
// Freezes on hold; inserts an empty entry when ID is stalled or empty.
module hazard_stage_tracker
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  insert_bubble,
    input  hz_entry_t             id_entry,
    output hz_entry_t [DEPTH-1:0] stages
);

    hz_entry_t [DEPTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (!hold) begin
            stage_d[0] = insert_bubble ? '0 : id_entry;
            for (int j = 1; j < DEPTH; j++) begin
                stage_d[j] = stage_q[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    assign stages = stage_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: load-use / branch-operand stalls,
// EX and ID forwarding selects, taken-branch flush and a saturating stall counter.
module pipe_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int POST_ID_STAGES = 3,
    parameter int LOAD_LAT       = 1,
    parameter bit FWD_EN         = 1'b1,
    parameter int CNT_W          = 16,
    localparam int FSEL_W        = $clog2(POST_ID_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_stall,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              id_branch_taken,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_flush,
    output logic              id_bubble,
    output logic [FSEL_W-1:0] ex_fwd_a,
    output logic [FSEL_W-1:0] ex_fwd_b,
    output logic [FSEL_W-1:0] id_fwd_a,
    output logic [FSEL_W-1:0] id_fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int N = POST_ID_STAGES;

    hz_entry_t [N-1:0] stage;
    hz_entry_t         id_entry;
    logic [HZ_AW-1:0]  rs_x, rt_x;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign rs_x = HZ_AW'(id_rs);
    assign rt_x = HZ_AW'(id_rt);

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = id_valid;
        id_entry.rd        = HZ_AW'(id_rd);
        id_entry.reg_write = id_reg_write;
        id_entry.is_load   = id_is_load;
        id_entry.rs        = rs_x;
        id_entry.rt        = rt_x;
    end

    hazard_stage_tracker #(.DEPTH(N)) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .hold          (ext_stall),
        .insert_bubble (stall | ~id_valid),
        .id_entry      (id_entry),
        .stages        (stage)
    );

    // Branches compare in ID, one stage earlier than EX consumers, hence j vs j+1.
    always_comb begin
        stall = 1'b0;
        for (int j = 0; j < N; j++) begin
            if ((id_use_rs && hz_match(stage[j], rs_x)) ||
                (id_use_rt && hz_match(stage[j], rt_x))) begin
                if (!FWD_EN ||
                    (id_is_branch ? (j < avail(stage[j].is_load, LOAD_LAT, FWD_EN, N))
                                  : (j + 1 < avail(stage[j].is_load, LOAD_LAT, FWD_EN, N))))
                    stall = 1'b1;
            end
        end
        stall = stall & id_valid;
    end

    // Scan oldest to youngest so the youngest eligible producer wins.
    always_comb begin
        ex_fwd_a = FSEL_W'(FWD_REGFILE);
        ex_fwd_b = FSEL_W'(FWD_REGFILE);
        id_fwd_a = FSEL_W'(FWD_REGFILE);
        id_fwd_b = FSEL_W'(FWD_REGFILE);
        for (int k = N - 1; k >= 1; k--) begin
            if (k >= avail(stage[k].is_load, LOAD_LAT, FWD_EN, N)) begin
                if (hz_match(stage[k], stage[0].rs)) ex_fwd_a = FSEL_W'(k);
                if (hz_match(stage[k], stage[0].rt)) ex_fwd_b = FSEL_W'(k);
                if (hz_match(stage[k], rs_x))        id_fwd_a = FSEL_W'(k);
                if (hz_match(stage[k], rt_x))        id_fwd_b = FSEL_W'(k);
            end
        end
    end

    assign pc_write    = !ext_stall && !stall;
    assign if_id_write = !ext_stall && !stall;
    assign id_bubble   = !ext_stall && stall;
    assign if_flush    = id_branch_taken && id_valid && !stall && !ext_stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: default controller plus a no-forwarding, 2-bit-counter variant.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, ext_stall, id_valid, id_use_rs, id_use_rt;
    logic       id_is_branch, id_branch_taken, id_reg_write, id_is_load;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        pc_write, if_id_write, if_flush, id_bubble;
    logic [1:0]  ex_fwd_a, ex_fwd_b, id_fwd_a, id_fwd_b;
    logic [15:0] stall_cnt;

    logic        nf_pc_write, nf_if_id_write, nf_if_flush, nf_id_bubble;
    logic [1:0]  nf_ex_fwd_a, nf_ex_fwd_b, nf_id_fwd_a, nf_id_fwd_b;
    logic [1:0]  nf_stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .POST_ID_STAGES(3), .LOAD_LAT(1), .FWD_EN(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush), .id_bubble(id_bubble),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
        .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .POST_ID_STAGES(3), .LOAD_LAT(1), .FWD_EN(1'b0), .CNT_W(2)) u_nofwd (
        .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .pc_write(nf_pc_write), .if_id_write(nf_if_id_write), .if_flush(nf_if_flush),
        .id_bubble(nf_id_bubble),
        .ex_fwd_a(nf_ex_fwd_a), .ex_fwd_b(nf_ex_fwd_b), .id_fwd_a(nf_id_fwd_a), .id_fwd_b(nf_id_fwd_b),
        .stall_cnt(nf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic br, input logic tk,
                          input logic [4:0] rd, input logic rw, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_is_branch = br; id_branch_taken = tk; id_rd = rd; id_reg_write = rw; id_is_load = ld;
    endtask

    task automatic t_nop();                                set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic t_alu(input logic [4:0] rd, rs, rt);    set_id(1, rs, rt, 1, 1, 0, 0, rd, 1, 0); endtask
    task automatic t_lw(input logic [4:0] rd, base);       set_id(1, base, 0, 1, 0, 0, 0, rd, 1, 1); endtask
    task automatic t_beq(input logic [4:0] rs, rt, input logic tk); set_id(1, rs, rt, 1, 1, 1, tk, 0, 0, 0); endtask

    task automatic drain();
        t_nop();
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b1; ext_stall = 1'b0; t_nop();
        step(); step();
        rst = 1'b0;
        #2;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_if_id_write", if_id_write, 1);
        chk("rst_if_flush", if_flush, 0);
        chk("rst_id_bubble", id_bubble, 0);
        chk("rst_ex_fwd_a", ex_fwd_a, 0);
        chk("rst_id_fwd_b", id_fwd_b, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // lw $2 ; add $3,$2,$4
        step(); t_lw(2, 1); #2;
        chk("lu_lw_no_bubble", id_bubble, 0);
        step(); t_alu(3, 2, 4); #2;
        chk("lu_bubble", id_bubble, 1);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_if_id_write", if_id_write, 0);
        step(); #2;
        chk("lu_bubble_clear", id_bubble, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        step(); t_nop(); #2;
        chk("lu_ex_fwd_a", ex_fwd_a, 2);
        chk("lu_ex_fwd_b", ex_fwd_b, 0);
        drain();

        // add $2 ; beq $2,$5
        t_alu(2, 1, 1); step();
        t_beq(2, 5, 0); #2;
        chk("ab_bubble", id_bubble, 1);
        step(); #2;
        chk("ab_bubble_clear", id_bubble, 0);
        chk("ab_id_fwd_a", id_fwd_a, 1);
        chk("ab_id_fwd_b", id_fwd_b, 0);
        step(); #2;
        chk("ab_stall_cnt", stall_cnt, 2);
        drain();

        // lw $2 ; beq $2,$5
        t_lw(2, 1); step();
        t_beq(2, 5, 0); #2;
        chk("lb_bubble1", id_bubble, 1);
        step(); #2;
        chk("lb_bubble2", id_bubble, 1);
        step(); #2;
        chk("lb_bubble_clear", id_bubble, 0);
        chk("lb_id_fwd_a", id_fwd_a, 2);
        step(); #2;
        chk("lb_stall_cnt", stall_cnt, 4);
        drain();

        // add $2 ; add $2 ; sub $6,$2,$2
        t_alu(2, 1, 1); step();
        t_alu(2, 7, 7); step();
        t_alu(6, 2, 2); #2;
        chk("yp_no_bubble", id_bubble, 0);
        step(); t_nop(); #2;
        chk("yp_ex_fwd_a", ex_fwd_a, 1);
        chk("yp_ex_fwd_b", ex_fwd_b, 1);
        drain();

        // writes to $0
        t_alu(0, 1, 1); step();
        t_alu(3, 0, 0); #2;
        chk("r0_no_bubble", id_bubble, 0);
        step(); t_beq(0, 0, 0); #2;
        chk("r0_ex_fwd_a", ex_fwd_a, 0);
        chk("r0_id_fwd_a", id_fwd_a, 0);
        chk("r0_branch_no_bubble", id_bubble, 0);
        step(); t_lw(0, 1); step();
        t_alu(3, 0, 0); #2;
        chk("r0_lw_no_bubble", id_bubble, 0);
        drain();

        // taken branch, no hazard
        t_beq(8, 9, 1); #2;
        chk("tb_flush", if_flush, 1);
        chk("tb_pc_write", pc_write, 1);
        step(); t_nop(); #2;
        chk("tb_flush_one_cycle", if_flush, 0);
        drain();

        // taken branch stalled by lw
        t_lw(2, 1); step();
        t_beq(2, 5, 1); #2;
        chk("ts_flush_s1", if_flush, 0);
        chk("ts_bubble_s1", id_bubble, 1);
        step(); #2;
        chk("ts_flush_s2", if_flush, 0);
        chk("ts_bubble_s2", id_bubble, 1);
        step(); #2;
        chk("ts_flush_release", if_flush, 1);
        chk("ts_bubble_release", id_bubble, 0);
        chk("ts_pc_write", pc_write, 1);
        step(); t_nop(); #2;
        chk("ts_flush_after", if_flush, 0);
        chk("ts_stall_cnt", stall_cnt, 6);
        drain();

        // ext_stall during load-use
        t_lw(2, 1); step();
        t_alu(3, 2, 4); ext_stall = 1'b1; #2;
        chk("es_pc_write", pc_write, 0);
        chk("es_if_id_write", if_id_write, 0);
        chk("es_bubble", id_bubble, 0);
        step(); step(); step(); #2;
        chk("es_bubble_held", id_bubble, 0);
        chk("es_stall_cnt", stall_cnt, 6);
        ext_stall = 1'b0; #1;
        chk("es_release_bubble", id_bubble, 1);
        step(); #2;
        chk("es_bubble_clear", id_bubble, 0);
        chk("es_stall_cnt_after", stall_cnt, 7);
        step(); t_nop(); #2;
        chk("es_ex_fwd_a", ex_fwd_a, 2);
        drain();

        // no-forwarding variant, 2-bit saturating counter
        rst = 1'b1; step(); rst = 1'b0; #2;
        chk("nf_rst_cnt", nf_stall_cnt, 0);
        t_alu(2, 1, 1); step();
        t_alu(3, 2, 2); #2;
        chk("nf_bubble1", nf_id_bubble, 1);
        chk("nf_pc_write", nf_pc_write, 0);
        step(); #2;
        chk("nf_bubble2", nf_id_bubble, 1);
        chk("nf_id_fwd_a", nf_id_fwd_a, 0);
        chk("fw_id_fwd_a", id_fwd_a, 1);
        step(); #2;
        chk("nf_bubble3", nf_id_bubble, 1);
        step(); #2;
        chk("nf_bubble_clear", nf_id_bubble, 0);
        chk("nf_stall_cnt3", nf_stall_cnt, 3);
        step(); t_alu(2, 1, 1); #2;
        chk("nf_ex_fwd_a", nf_ex_fwd_a, 0);
        chk("nf_ex_fwd_b", nf_ex_fwd_b, 0);
        step(); t_alu(5, 2, 2); #2;
        chk("nf_sat_bubble", nf_id_bubble, 1);
        step(); step(); step(); #2;
        chk("nf_sat_clear", nf_id_bubble, 0);
        chk("nf_stall_cnt_sat", nf_stall_cnt, 3);
        drain();

        // reset mid-stall
        t_lw(2, 1); step();
        t_alu(3, 2, 4); #2;
        chk("rm_bubble", id_bubble, 1);
        rst = 1'b1;
        step(); #2;
        chk("rm_bubble_cleared", id_bubble, 0);
        chk("rm_pc_write", pc_write, 1);
        chk("rm_if_flush", if_flush, 0);
        chk("rm_stall_cnt", stall_cnt, 0);
        chk("rm_ex_fwd_a", ex_fwd_a, 0);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
